// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - asynchronous-frame serial transmitter (start, 8 data LSB first, optional even parity, stop)
module serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Data,
  output logic       Tx,
  output logic       Busy,
  output logic       Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             par, par_nx;
  logic             tx_q, tx_nx;
  logic             done_q, done_nx;
  logic             bit_end;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shreg  <= shreg_nx;
      par    <= par_nx;
      tx_q   <= tx_nx;
      done_q <= done_nx;
    end
  end

  assign bit_end = (cnt == CNT_MAX);

  // Tx is computed one edge ahead so the line value is taken straight from a flop.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    par_nx   = par;
    tx_nx    = tx_q;
    done_nx  = 1'b0;

    if (state != S_IDLE) begin
      cnt_nx = bit_end ? '0 : cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        tx_nx  = 1'b1;
        cnt_nx = '0;
        if (Start) begin
          state_nx = S_START;
          shreg_nx = Data;
          par_nx   = ^Data;
          idx_nx   = 3'd0;
          tx_nx    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_nx = S_DATA;
          tx_nx    = shreg[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_nx = S_PARITY;
              tx_nx    = par;
            end else begin
              state_nx = S_STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            shreg_nx = {1'b0, shreg[7:1]};
            idx_nx   = idx + 3'd1;
            tx_nx    = shreg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_nx = S_STOP;
          tx_nx    = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_nx = S_IDLE;
          tx_nx    = 1'b1;
          done_nx  = 1'b1;
        end
      end

      default: begin
        state_nx = S_IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

  assign Tx   = tx_q;
  assign Busy = (state != S_IDLE);
  assign Done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed self-checking bench for serial_tx
module tb_serial_tx;

  logic       clk;
  logic       rst;
  logic [2:0] start;
  logic [7:0] data [3];
  logic [2:0] tx, busy, done;

  int tests = 0;
  int fails = 0;

  // dut 0: N=4 P=0, dut 1: N=4 P=1, dut 2: N=2 P=0
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_n4p0 (
    .Clk(clk), .Reset(rst), .Start(start[0]), .Data(data[0]),
    .Tx(tx[0]), .Busy(busy[0]), .Done(done[0]));
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_n4p1 (
    .Clk(clk), .Reset(rst), .Start(start[1]), .Data(data[1]),
    .Tx(tx[1]), .Busy(busy[1]), .Done(done[1]));
  serial_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) u_n2p0 (
    .Clk(clk), .Reset(rst), .Start(start[2]), .Data(data[2]),
    .Tx(tx[2]), .Busy(busy[2]), .Done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int j, input int p);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && p != 0) return ^b;
    return 1'b1;
  endfunction

  task automatic accept(input int d, input logic [7:0] b);
    data[d]  = b;
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
  endtask

  // Called just after the accepting edge; returns in the Done cycle.
  task automatic check_frame(input int d, input int n, input int p,
                             input logic [7:0] b, input logic disturb);
    int f;
    f = (10 + p) * n;
    for (int c = 0; c < f; c++) begin
      if (disturb) begin
        if (c == 10) start[d] = 1'b1;
        if (c == 11) start[d] = 1'b0;
        if (c == 15) data[d] = 8'hFF;
      end
      chk($sformatf("tx d%0d c%0d", d, c), tx[d], exp_bit(b, c / n, p));
      chk($sformatf("busy d%0d c%0d", d, c), busy[d], 1'b1);
      chk($sformatf("done d%0d c%0d", d, c), done[d], 1'b0);
      step();
    end
    chk($sformatf("end_tx d%0d", d), tx[d], 1'b1);
    chk($sformatf("end_busy d%0d", d), busy[d], 1'b0);
    chk($sformatf("end_done d%0d", d), done[d], 1'b1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx d%0d", i), tx[i], 1'b1);
      chk($sformatf("rst_busy d%0d", i), busy[i], 1'b0);
      chk($sformatf("rst_done d%0d", i), done[i], 1'b0);
    end
    rst = 1'b0;
    step();

    // basic frame A5
    accept(0, 8'hA5);
    check_frame(0, 4, 0, 8'hA5, 1'b0);
    step();
    chk("a5_done_clear", done[0], 1'b0);

    // parity frames
    accept(1, 8'h07);
    check_frame(1, 4, 1, 8'h07, 1'b0);
    step();
    chk("p07_done_clear", done[1], 1'b0);
    accept(1, 8'h03);
    check_frame(1, 4, 1, 8'h03, 1'b0);
    step();
    chk("p03_done_clear", done[1], 1'b0);

    // ignored Start and Data change mid-frame
    accept(0, 8'h5A);
    check_frame(0, 4, 0, 8'h5A, 1'b1);
    step();
    chk("ign_done_once", done[0], 1'b0);
    chk("ign_no_restart", busy[0], 1'b0);
    repeat (4) step();
    chk("ign_still_idle", busy[0], 1'b0);

    // back-to-back with Start held high
    data[2]  = 8'h00;
    start[2] = 1'b1;
    step();
    data[2] = 8'hFF;
    check_frame(2, 2, 0, 8'h00, 1'b0);
    step();
    start[2] = 1'b0;
    check_frame(2, 2, 0, 8'hFF, 1'b0);
    step();
    chk("b2b_done_clear", done[2], 1'b0);
    chk("b2b_idle", busy[2], 1'b0);

    // asynchronous reset during DATA_BITS while Tx is low
    accept(0, 8'h3C);
    repeat (6) step();
    chk("pre_rst_tx", tx[0], 1'b0);
    chk("pre_rst_busy", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx[0], 1'b1);
    chk("async_rst_busy", busy[0], 1'b0);
    chk("async_rst_done", done[0], 1'b0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("abort_done c%0d", c), done[0], 1'b0);
      chk($sformatf("abort_tx c%0d", c), tx[0], 1'b1);
      chk($sformatf("abort_busy c%0d", c), busy[0], 1'b0);
    end
    accept(0, 8'h3C);
    check_frame(0, 4, 0, 8'h3C, 1'b0);
    step();
    chk("post_rst_done_clear", done[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Serial transmitter that serialises one stored 8-bit value per request onto a single line as an asynchronous frame (start bit, data LSB first, optional parity, stop bit). It pairs with the lab storage elements: a byte held in switches or latches is handed over on a Start pulse and driven out bit by bit for a receiver or LED observation. The block has one clock domain and an internal bit-period divider, and it raises completion flags for the controlling logic.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per serial bit (115200 baud at 50 MHz). Legal range 2..65535.
- PARITY_EN, default 0: when set to 1, the block inserts an even-parity bit between D7 and stop.
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  transmit request, sampled on a rising edge of Clk.
- Data  input  8  byte to send; captured only on an accepted Start.
- Tx  output  1  serial line; idles high.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle pulse at frame completion.

## Operation
- FSM states and transitions:
  - IDLE: on Start=1, go to START_BIT.
  - START_BIT: go to DATA_BITS.
  - DATA_BITS: go to PARITY_BIT when PARITY_EN=1, otherwise go to STOP_BIT.
  - PARITY_BIT: go to STOP_BIT.
  - STOP_BIT: go to IDLE.
  - Every state except IDLE lasts exactly CLKS_PER_BIT cycles. DATA_BITS lasts 8×CLKS_PER_BIT cycles.
- Accepted Start (state IDLE, Start=1 at an edge):
  - Copy Data into an internal shift register.
  - Clear the baud counter and the bit index.
- Data changes after acceptance have no effect on the frame in flight.
- Start while Busy=1 is ignored. Requests are not queued.
- Start held high continuously produces back-to-back frames, each separated by one IDLE cycle.
- Tx value per state:
  - IDLE: 1.
  - START_BIT: 0.
  - DATA_BITS: shift register bit 0, with the register shifted right at each bit boundary.
  - PARITY_BIT: XOR of the 8 captured bits.
  - STOP_BIT: 1.
- Tx is registered and glitch-free.
- Baud counter width is ceil(log2(CLKS_PER_BIT)) bits. It counts 0..CLKS_PER_BIT-1, and a bit boundary occurs on the edge where it equals CLKS_PER_BIT-1. The bit index is 3 bits and counts 0..7.
- Busy is 1 in every state except IDLE.
- Done is 1 only during the first IDLE cycle after STOP_BIT.
- Reset, including mid-frame: takes effect immediately and asynchronously.
  - State becomes IDLE, Tx=1, Busy=0, Done=0, and counters and shift register are 0.
  - An aborted frame is not resumed, and Done is not raised for it.

## Timing
- Let edge k be the edge at which Start is accepted, N=CLKS_PER_BIT, and P=PARITY_EN.
- After edge k: Tx=0, Busy=1.
- After edge k+N·(1+i): Tx=Data[i], for i=0..7.
- After edge k+9N (P=1 only): Tx=parity.
- After edge k+(9+P)N: Tx=1 (stop bit).
- After edge k+(10+P)N: Busy=0, Done=1.
- After edge k+(10+P)N+1: Done=0.
- Frame length is (10+P)·N cycles. Latency from the Start edge to the first Tx change is 0 cycles past that edge.
- The earliest next acceptance is edge k+(10+P)N+1, which is the Done cycle. Start high in the Done cycle is accepted.

## Test plan
- Reset: assert Reset mid-cycle with Tx=0 and no clock -> Tx=1, Busy=0, Done=0 immediately.
- Basic frame:
  - Setup: N=4, P=0, Data=8'hA5, one-cycle Start.
  - Required response: Tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1.
  - Busy is high for 40 cycles. Done pulses once at cycle 40.
- Parity:
  - Setup: N=4, P=1.
  - Data=8'h07 -> parity bit 1, frame 44 cycles.
  - Data=8'h03 -> parity bit 0.
- Ignored request and data stability:
  - Stimulus: Start pulsed at cycle 10 of a frame, and Data changed to 8'hFF mid-frame.
  - Required response: the original byte is transmitted and exactly one Done pulse occurs.
- Back-to-back:
  - Stimulus: Start held high with N=2, Data=8'h00 then 8'hFF.
  - Required response: two frames separated by exactly one IDLE cycle (Tx=1, Busy=0, Done=1).
- Mid-frame reset:
  - Stimulus: Reset pulsed during DATA_BITS, then Start with Data=8'h3C.
  - Required response: Tx returns high, no Done for the aborted frame, and the new frame is bit-exact.
